// File: rtl/motor_pkg.sv
// Shared types and widths for the motor step-generation pipeline.
package motor_pkg;

  localparam int FRAC_W = 16;
  localparam int CNT_W  = 24;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    FILL,
    FIRE,
    COUNT,
    DONE_ST
  } step_state_t;

endpackage

// File: rtl/step_period_calc.sv
// Turns a pair of successive Q16.16 roots into a clamped step period, one cycle later.
module step_period_calc
  import motor_pkg::*;
#(
  parameter int unsigned MIN_PERIOD = 8,
  parameter int unsigned MAX_PERIOD = 2**24-1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [31:0]      root_i,
  input  logic [31:0]      prev_i,
  input  logic [31:0]      c0_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic             err_o
);

  localparam int RAW_W = 64 - FRAC_W;
  localparam logic [RAW_W-1:0] MIN_RAW = RAW_W'(MIN_PERIOD);
  localparam logic [RAW_W-1:0] MAX_RAW = RAW_W'(MAX_PERIOD);

  logic [31:0]      diff;
  logic [63:0]      prod;
  logic [RAW_W-1:0] d_raw;
  logic [CNT_W-1:0] period_d, period_q;
  logic             err_d, err_q, valid_q;

  always_comb begin
    diff  = root_i - prev_i;
    prod  = {32'd0, c0_i} * {32'd0, diff};
    d_raw = prod[63:FRAC_W];
    err_d = root_i < prev_i;
    // A decreasing root means the upstream stage is broken; park at the slowest rate.
    if (err_d)                 period_d = CNT_W'(MAX_PERIOD);
    else if (d_raw < MIN_RAW)  period_d = CNT_W'(MIN_PERIOD);
    else if (d_raw > MAX_RAW)  period_d = CNT_W'(MAX_PERIOD);
    else                       period_d = d_raw[CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      period_q <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        period_q <= period_d;
        err_q    <= err_d;
      end
    end
  end

  assign valid_o  = valid_q;
  assign period_o = period_q;
  assign err_o    = err_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Step pulse generator: pulls roots, converts differences into step intervals and
// emits one STEP pulse per interval, prefetching the next period while counting.
module step_pulse_gen
  import motor_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned MIN_PERIOD  = 8,
  parameter int unsigned MAX_PERIOD  = 2**24-1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        ABORT,
  input  logic [31:0] C0,
  input  logic [15:0] TOTAL,
  input  logic [31:0] ROOT,
  input  logic        ROOT_VALID,
  output logic        ROOT_READY,
  output logic        STEP,
  output logic [15:0] STEP_IDX,
  output logic        BUSY,
  output logic        DONE,
  output logic        STALL,
  output logic        ERR
);

  localparam logic [CNT_W-1:0] PW = CNT_W'(PULSE_WIDTH);

  step_state_t      state_q, state_d;
  logic [31:0]      c0_q, c0_d, r_prev_q, r_prev_d;
  logic [15:0]      total_q, total_d, acc_q, acc_d, idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, buf_q, buf_d;
  logic             buf_vld_q, buf_vld_d, stall_q, stall_d, err_q, err_d;

  logic             active, more, xfer, fire;
  logic             calc_vld, calc_err, have_next;
  logic [CNT_W-1:0] calc_per, next_per;

  assign active     = (state_q == PRIME) || (state_q == FILL) ||
                      (state_q == FIRE)  || (state_q == COUNT);
  assign more       = acc_q != total_q;
  // Calc output counts as occupying the buffer so only one root is ever in flight.
  assign ROOT_READY = active && !ABORT && !buf_vld_q && !calc_vld && more;
  assign xfer       = ROOT_VALID && ROOT_READY;
  assign have_next  = buf_vld_q || calc_vld;
  assign next_per   = buf_vld_q ? buf_q : calc_per;

  step_period_calc #(
    .MIN_PERIOD(MIN_PERIOD),
    .MAX_PERIOD(MAX_PERIOD)
  ) u_calc (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .valid_i (xfer && (state_q != PRIME)),
    .root_i  (ROOT),
    .prev_i  (r_prev_q),
    .c0_i    (c0_q),
    .valid_o (calc_vld),
    .period_o(calc_per),
    .err_o   (calc_err)
  );

  always_comb begin
    state_d   = state_q;
    c0_d      = c0_q;
    total_d   = total_q;
    r_prev_d  = r_prev_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    stall_d   = stall_q;
    err_d     = err_q;
    fire      = 1'b0;

    if (calc_vld) begin
      buf_vld_d = 1'b1;
      buf_d     = calc_per;
      if (calc_err) err_d = 1'b1;
    end
    if (xfer) begin
      r_prev_d = ROOT;
      if (state_q != PRIME) acc_d = acc_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (START) begin
          c0_d      = C0;
          total_d   = TOTAL;
          r_prev_d  = '0;
          acc_d     = '0;
          idx_d     = '0;
          buf_vld_d = 1'b0;
          stall_d   = 1'b0;
          err_d     = 1'b0;
          state_d   = (TOTAL == 16'd0) ? DONE_ST : PRIME;
        end
      end
      PRIME: if (xfer) state_d = FILL;
      FILL:  if (have_next) fire = 1'b1;
      FIRE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PW) state_d = COUNT;
      end
      COUNT: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q counts cycles since STEP rose, starting at 1 in the rise cycle.
        if (cnt_q >= per_q) begin
          if (idx_q == total_q) begin
            state_d = DONE_ST;
          end else if (have_next) begin
            fire = 1'b1;
          end else begin
            state_d = FILL;
            stall_d = 1'b1;
          end
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fire) begin
      state_d   = FIRE;
      cnt_d     = CNT_W'(1);
      per_d     = next_per;
      idx_d     = idx_q + 16'd1;
      buf_vld_d = 1'b0;
    end

    if (ABORT) begin
      state_d   = IDLE;
      buf_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      c0_q      <= '0;
      total_q   <= '0;
      r_prev_q  <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      per_q     <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      stall_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      c0_q      <= c0_d;
      total_q   <= total_d;
      r_prev_q  <= r_prev_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
    end
  end

  assign STEP     = (state_q == FIRE);
  assign STEP_IDX = idx_q;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = (state_q == DONE_ST);
  assign STALL    = stall_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: root feeder, edge monitor and one task per scenario.
module tb_step_pulse_gen;

  logic        CLK = 1'b0;
  logic        RESET, START, ABORT;
  logic [31:0] C0, ROOT;
  logic [15:0] TOTAL, STEP_IDX;
  logic        ROOT_VALID, ROOT_READY, STEP, BUSY, DONE, STALL, ERR;

  step_pulse_gen #(
    .PULSE_WIDTH(4),
    .MIN_PERIOD (8),
    .MAX_PERIOD (2**24-1)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .ABORT     (ABORT),
    .C0        (C0),
    .TOTAL     (TOTAL),
    .ROOT      (ROOT),
    .ROOT_VALID(ROOT_VALID),
    .ROOT_READY(ROOT_READY),
    .STEP      (STEP),
    .STEP_IDX  (STEP_IDX),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .STALL     (STALL),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: cycle numbers of STEP rises and DONE pulses.
  int   rise_cnt = 0, done_cnt = 0, done_cyc = 0;
  int   rise_cyc [64];
  logic step_prev = 1'b0;
  always @(negedge CLK) begin
    step_prev <= STEP;
    if (STEP && !step_prev) begin
      rise_cyc[rise_cnt % 64] <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    if (DONE) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // Root feeder: offers roots[] in order, holding VALID low gap[i] cycles before root i.
  logic [31:0] roots [8];
  int          gap [8];
  int          n_roots = 0, feed_gen = 0, fidx = 0;
  int          hs_cyc [8];
  initial begin : feeder
    int my_gen;
    int gap_cnt;
    my_gen = 0;
    gap_cnt = 0;
    ROOT = '0;
    ROOT_VALID = 1'b0;
    forever begin
      @(negedge CLK);
      if (feed_gen != my_gen) begin
        my_gen = feed_gen;
        fidx = 0;
        gap_cnt = gap[0];
      end
      if (fidx < n_roots && gap_cnt > 0) begin
        ROOT_VALID = 1'b0;
        gap_cnt--;
      end else if (fidx < n_roots) begin
        ROOT = roots[fidx];
        ROOT_VALID = 1'b1;
      end else begin
        ROOT_VALID = 1'b0;
      end
      #4;
      if (ROOT_VALID && ROOT_READY) begin
        hs_cyc[fidx] = cyc;
        fidx++;
        gap_cnt = (fidx < 8) ? gap[fidx] : 0;
      end
    end
  end

  int chk_cnt = 0, pass_cnt = 0;

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic load_roots(input int n, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3, input int g2);
    roots[0] = r0; roots[1] = r1; roots[2] = r2; roots[3] = r3;
    for (int i = 0; i < 8; i++) gap[i] = 0;
    gap[2] = g2;
    n_roots = n;
    feed_gen++;
    tick();
  endtask

  task automatic pulse_start(input logic [31:0] c0, input logic [15:0] tot, output int c);
    C0 = c0;
    TOTAL = tot;
    START = 1'b1;
    c = cyc;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_rises(input int target, input int budget, output bit ok);
    int n = 0;
    while (rise_cnt < target && n < budget) begin
      tick();
      n++;
    end
    ok = (rise_cnt >= target);
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic test_reset();
    logic [21:0] outs;
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; C0 = '0; TOTAL = '0;
    repeat (3) tick();
    outs = {STEP, BUSY, DONE, STALL, ERR, ROOT_READY, STEP_IDX};
    chk_cnt++;
    if (outs !== 22'd0) $display("FAIL reset_outputs: got %h want 0", outs);
    else pass_cnt++;
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int b, bd, sc, r1, r2;
    bit ok;
    b = rise_cnt; bd = done_cnt;
    load_roots(3, 32'h0, 32'h10000, 32'h16A0A, 32'h0, 0);
    pulse_start(1000, 2, sc);
    wait_rises(b + 1, 100, ok);
    r1 = rise_cyc[b % 64];
    chk_cnt++;
    if (!ok || r1 !== hs_cyc[1] + 2) $display("FAIL basic_first_rise: got %0d want %0d (ok=%0d)", r1, hs_cyc[1] + 2, ok);
    else pass_cnt++;
    // START while busy must not re-latch C0/TOTAL
    C0 = 32'd1; TOTAL = 16'd5; START = 1'b1;
    tick();
    START = 1'b0;
    wait_rises(b + 2, 1100, ok);
    r2 = rise_cyc[(b + 1) % 64];
    chk_cnt++;
    if (!ok || r2 - r1 !== 1000) $display("FAIL basic_d1: got %0d want 1000 (ok=%0d)", r2 - r1, ok);
    else pass_cnt++;
    wait_done(bd + 1, 600, ok);
    chk_cnt++;
    if (!ok || done_cyc - r2 !== 414) $display("FAIL basic_d2: got %0d want 414 (ok=%0d)", done_cyc - r2, ok);
    else pass_cnt++;
    repeat (5) tick();
    chk_cnt++;
    if (done_cnt - bd !== 1) $display("FAIL basic_done_once: got %0d want 1", done_cnt - bd);
    else pass_cnt++;
    chk_cnt++;
    if (STEP_IDX !== 16'd2) $display("FAIL basic_step_idx: got %0d want 2", STEP_IDX);
    else pass_cnt++;
    chk_cnt++;
    if ({BUSY, ROOT_READY, STEP} !== 3'b000) $display("FAIL basic_idle_after: got %b want 000", {BUSY, ROOT_READY, STEP});
    else pass_cnt++;
  endtask

  task automatic test_clamp();
    int b, bd, sc, r1, r2;
    bit ok;
    b = rise_cnt; bd = done_cnt;
    load_roots(3, 32'h0, 32'h10000, 32'h20000, 32'h0, 0);
    pulse_start(4, 2, sc);
    wait_rises(b + 2, 200, ok);
    r1 = rise_cyc[b % 64];
    r2 = rise_cyc[(b + 1) % 64];
    chk_cnt++;
    if (!ok || r2 - r1 !== 8) $display("FAIL clamp_rise_to_rise: got %0d want 8 (ok=%0d)", r2 - r1, ok);
    else pass_cnt++;
    wait_done(bd + 1, 100, ok);
    chk_cnt++;
    if (!ok || done_cyc - r2 !== 8) $display("FAIL clamp_last_period: got %0d want 8 (ok=%0d)", done_cyc - r2, ok);
    else pass_cnt++;
    chk_cnt++;
    if (STEP_IDX !== 16'd2) $display("FAIL clamp_step_idx: got %0d want 2", STEP_IDX);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int b, bd, sc, r1, r2;
    bit ok;
    b = rise_cnt; bd = done_cnt;
    load_roots(3, 32'h0, 32'h10000, 32'h16A0A, 32'h0, 2000);
    pulse_start(1000, 2, sc);
    wait_rises(b + 1, 100, ok);
    wait_rises(b + 2, 3000, ok);
    r1 = rise_cyc[b % 64];
    r2 = rise_cyc[(b + 1) % 64];
    chk_cnt++;
    if (!ok || r2 !== hs_cyc[2] + 2) $display("FAIL stall_late_rise: got %0d want %0d (ok=%0d)", r2, hs_cyc[2] + 2, ok);
    else pass_cnt++;
    chk_cnt++;
    if (r2 - r1 <= 1000) $display("FAIL stall_gap: got %0d want >1000", r2 - r1);
    else pass_cnt++;
    chk_cnt++;
    if (STALL !== 1'b1) $display("FAIL stall_flag: got %b want 1", STALL);
    else pass_cnt++;
    wait_done(bd + 1, 600, ok);
    chk_cnt++;
    if (!ok || done_cyc - r2 !== 414) $display("FAIL stall_d2: got %0d want 414 (ok=%0d)", done_cyc - r2, ok);
    else pass_cnt++;
  endtask

  task automatic test_err();
    int b, bd, sc, r1, r2;
    bit ok;
    b = rise_cnt; bd = done_cnt;
    load_roots(4, 32'h0, 32'h20000, 32'h10000, 32'h20000, 0);
    pulse_start(16, 3, sc);
    chk_cnt++;
    if (STALL !== 1'b0) $display("FAIL err_start_clears_stall: got %b want 0", STALL);
    else pass_cnt++;
    wait_rises(b + 2, 200, ok);
    r1 = rise_cyc[b % 64];
    r2 = rise_cyc[(b + 1) % 64];
    chk_cnt++;
    if (!ok || r2 - r1 !== 32) $display("FAIL err_d1: got %0d want 32 (ok=%0d)", r2 - r1, ok);
    else pass_cnt++;
    chk_cnt++;
    if (ERR !== 1'b1) $display("FAIL err_flag: got %b want 1", ERR);
    else pass_cnt++;
    // d2 is MAX_PERIOD, so step 3 must stay far away
    repeat (1000) tick();
    chk_cnt++;
    if (rise_cnt !== b + 2 || BUSY !== 1'b1) $display("FAIL err_max_period: rises %0d want %0d, busy %b want 1", rise_cnt - b, 2, BUSY);
    else pass_cnt++;
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    b = rise_cnt; bd = done_cnt;
    load_roots(2, 32'h0, 32'h10000, 32'h0, 32'h0, 0);
    pulse_start(16, 1, sc);
    chk_cnt++;
    if (ERR !== 1'b0) $display("FAIL err_start_clears: got %b want 0", ERR);
    else pass_cnt++;
    wait_rises(b + 1, 100, ok);
    r1 = rise_cyc[b % 64];
    wait_done(bd + 1, 100, ok);
    chk_cnt++;
    if (!ok || done_cyc - r1 !== 16) $display("FAIL err_rerun_period: got %0d want 16 (ok=%0d)", done_cyc - r1, ok);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int b, bd, sc, r1;
    bit ok;
    b = rise_cnt; bd = done_cnt;
    load_roots(3, 32'h0, 32'h10000, 32'h16A0A, 32'h0, 0);
    pulse_start(1000, 2, sc);
    wait_rises(b + 1, 100, ok);
    chk_cnt++;
    if (!ok || STEP !== 1'b1) $display("FAIL abort_in_fire: step %b want 1 (ok=%0d)", STEP, ok);
    else pass_cnt++;
    ABORT = 1'b1; START = 1'b1; TOTAL = 16'd1;
    tick();
    ABORT = 1'b0; START = 1'b0;
    chk_cnt++;
    if ({STEP, BUSY, ROOT_READY} !== 3'b000) $display("FAIL abort_outputs: got %b want 000", {STEP, BUSY, ROOT_READY});
    else pass_cnt++;
    repeat (1200) tick();
    chk_cnt++;
    if (done_cnt !== bd || rise_cnt !== b + 1) $display("FAIL abort_quiet: dones %0d want 0, rises %0d want 1", done_cnt - bd, rise_cnt - b);
    else pass_cnt++;
    b = rise_cnt; bd = done_cnt;
    load_roots(2, 32'h0, 32'h10000, 32'h0, 32'h0, 0);
    pulse_start(1000, 1, sc);
    wait_rises(b + 1, 100, ok);
    r1 = rise_cyc[b % 64];
    chk_cnt++;
    if (!ok || r1 !== hs_cyc[1] + 2) $display("FAIL abort_restart_rise: got %0d want %0d (ok=%0d)", r1, hs_cyc[1] + 2, ok);
    else pass_cnt++;
    wait_done(bd + 1, 1100, ok);
    chk_cnt++;
    if (!ok || done_cyc - r1 !== 1000) $display("FAIL abort_restart_period: got %0d want 1000 (ok=%0d)", done_cyc - r1, ok);
    else pass_cnt++;
    chk_cnt++;
    if (STEP_IDX !== 16'd1) $display("FAIL abort_restart_idx: got %0d want 1", STEP_IDX);
    else pass_cnt++;
  endtask

  task automatic test_reset_total0();
    int b, bd, sc;
    bit ok;
    logic [21:0] outs;
    b = rise_cnt;
    load_roots(3, 32'h0, 32'h10000, 32'h16A0A, 32'h0, 0);
    pulse_start(1000, 2, sc);
    wait_rises(b + 1, 100, ok);
    repeat (20) tick();
    RESET = 1'b1;
    tick();
    outs = {STEP, BUSY, DONE, STALL, ERR, ROOT_READY, STEP_IDX};
    chk_cnt++;
    if (!ok || outs !== 22'd0) $display("FAIL reset_mid_count: got %h want 0 (ok=%0d)", outs, ok);
    else pass_cnt++;
    RESET = 1'b0;
    tick();
    b = rise_cnt; bd = done_cnt;
    pulse_start(0, 0, sc);
    chk_cnt++;
    if (DONE !== 1'b1 || cyc !== sc + 1) $display("FAIL total0_done: done %b at %0d want 1 at %0d", DONE, cyc, sc + 1);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({DONE, BUSY} !== 2'b00 || done_cnt !== bd + 1) $display("FAIL total0_single: done/busy %b want 00, dones %0d want 1", {DONE, BUSY}, done_cnt - bd);
    else pass_cnt++;
    chk_cnt++;
    if (rise_cnt !== b || STEP_IDX !== 16'd0) $display("FAIL total0_no_step: rises %0d idx %0d want 0 0", rise_cnt - b, STEP_IDX);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_stall();
    test_err();
    test_abort();
    test_reset_total0();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
